// File: rtl/pm_loader.sv
// Fills program memory from a framed byte stream (SYNC, LEN_H, LEN_L, N x {lo,hi}, CHK) and holds the core in reset while loading.
// Write pulse lands one cycle after the high byte is accepted; o_rx_ready drops during WRITE and DONE so the sender holds its byte.
module pm_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] MAX_WORDS = 16'd4096,
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic        o_PMWE,
  output logic [15:0] o_PMADDR,
  output logic [15:0] o_PMWDATA,
  output logic        o_core_reset,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_H, S_LEN_L, S_DATA_L, S_DATA_H, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_nx;
  logic        acc;
  logic        is_sync;
  logic [15:0] len, cnt, addr;
  logic [15:0] len_full, cnt_inc;
  logic [7:0]  lo_byte, chk;

  assign acc      = i_rx_valid && o_rx_ready;
  assign is_sync  = (i_rx_data == SYNC_BYTE);
  assign len_full = {len[15:8], i_rx_data};
  assign cnt_inc  = cnt + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    o_rx_ready = 1'b1;
    o_PMWE     = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    o_error    = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (acc && is_sync) state_nx = S_LEN_H;
      end
      S_LEN_H:  if (acc) state_nx = S_LEN_L;
      S_LEN_L: begin
        if (acc) begin
          if (len_full > MAX_WORDS)  state_nx = S_ERROR;
          else if (len_full == 16'd0) state_nx = S_CHECK;
          else                        state_nx = S_DATA_L;
        end
      end
      S_DATA_L: if (acc) state_nx = S_DATA_H;
      S_DATA_H: if (acc) state_nx = S_WRITE;
      S_WRITE: begin
        o_rx_ready = 1'b0;
        o_PMWE     = 1'b1;
        state_nx   = (cnt_inc == len) ? S_CHECK : S_DATA_L;
      end
      S_CHECK: begin
        if (acc) state_nx = (i_rx_data == chk) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        o_rx_ready = 1'b0;
        o_done     = 1'b1;
        state_nx   = S_IDLE;
      end
      S_ERROR: begin
        o_busy  = 1'b0;
        o_error = 1'b1;
        if (acc && is_sync) state_nx = S_LEN_H;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Address/data are captured with the high byte so the write cycle drives registered values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      len          <= 16'd0;
      cnt          <= 16'd0;
      addr         <= BASE_ADDR;
      lo_byte      <= 8'd0;
      chk          <= 8'd0;
      o_PMADDR     <= BASE_ADDR;
      o_PMWDATA    <= 16'd0;
      o_core_reset <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (acc && is_sync) begin
            cnt          <= 16'd0;
            chk          <= 8'd0;
            addr         <= BASE_ADDR;
            o_core_reset <= 1'b1;
          end
        end
        S_LEN_H: if (acc) len[15:8] <= i_rx_data;
        S_LEN_L: if (acc) len[7:0]  <= i_rx_data;
        S_DATA_L: begin
          if (acc) begin
            lo_byte <= i_rx_data;
            chk     <= chk + i_rx_data;
          end
        end
        S_DATA_H: begin
          if (acc) begin
            chk       <= chk + i_rx_data;
            o_PMADDR  <= addr;
            o_PMWDATA <= {i_rx_data, lo_byte};
          end
        end
        S_WRITE: begin
          addr <= addr + 16'd1;
          cnt  <= cnt_inc;
        end
        S_CHECK: if (acc && i_rx_data == chk) o_core_reset <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pm_loader.md
Name: pm_loader

Overview:
- Writer side of the program-memory interface. The fetch path only reads program memory; this block fills a writable program memory from a byte stream, for example the output of a UART receiver.
- While a load is in progress it holds the core in reset through o_core_reset, then releases the core on a successful load.
- It sits beside the fetch controller, and its write port is muxed onto the program-memory port.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_WORDS, 16'd4096, largest accepted word count.
- BASE_ADDR, 16'h0000, first program-memory word address written.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  8  incoming byte.
- i_rx_valid  in  1  i_rx_data is valid this cycle.
- o_rx_ready  out  1  loader accepts a byte this cycle.
- o_PMWE  out  1  program-memory write enable, one-cycle pulse.
- o_PMADDR  out  16  program-memory word address.
- o_PMWDATA  out  16  program-memory write data.
- o_core_reset  out  1  holds the core in reset.
- o_busy  out  1  a frame is in progress.
- o_done  out  1  one-cycle pulse on successful load.
- o_error  out  1  sticky error flag, cleared on the next accepted SYNC_BYTE or on i_reset.

Behaviour:
- Handshake: a byte is accepted on a rising edge where i_rx_valid && o_rx_ready. Unaccepted bytes are neither consumed nor lost; the sender holds them.
- Frame format, in order:
  - SYNC_BYTE.
  - LEN_H, LEN_L: word count N.
  - N words, each sent low byte then high byte.
  - CHK: 8-bit sum mod 256 of all 2N data bytes.
- States: IDLE, LEN_H, LEN_L, DATA_L, DATA_H, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - Accepted byte == SYNC_BYTE → LEN_H. Clear o_error, the checksum, and the word counter; set address = BASE_ADDR.
  - Any other byte is consumed and ignored.
- LEN_H → LEN_L, latching N[15:8].
- LEN_L latches N[7:0], then:
  - if N > MAX_WORDS → ERROR;
  - if N == 0 → CHECK;
  - otherwise → DATA_L.
- DATA_L latches the low byte → DATA_H.
- DATA_H latches the high byte → WRITE.
  - Both data bytes are added into the 8-bit checksum; the add wraps.
- WRITE (exactly 1 cycle):
  - o_PMWE = 1, o_PMADDR = current address, o_PMWDATA = {high, low}.
  - o_rx_ready = 0 in this cycle.
  - Next cycle: address increments by 1 (16-bit wrap) and the word counter increments.
  - If the counter now equals N → CHECK, otherwise → DATA_L.
- CHECK:
  - Accepted byte == checksum → DONE.
  - Any other byte → ERROR.
- DONE (1 cycle):
  - o_done = 1, o_rx_ready = 0, o_core_reset drops at the same edge that enters DONE → IDLE.
- ERROR:
  - o_error = 1 and o_core_reset stays 1.
  - o_rx_ready = 1; non-sync bytes are ignored.
  - SYNC_BYTE starts a new frame (→ LEN_H, o_error cleared).
- o_rx_ready = 1 in IDLE, LEN_H, LEN_L, DATA_L, DATA_H, CHECK and ERROR.
- o_busy = 1 in every state except IDLE and ERROR.
- o_core_reset:
  - set at the edge accepting SYNC_BYTE;
  - cleared on entry to DONE;
  - held through ERROR until a successful load.
- o_PMADDR/o_PMWDATA are registered. Their value is don't-care while o_PMWE = 0, but they hold their last value.
- Latency: the last high byte is accepted at edge k; o_PMWE is high during cycle k+1.
- Reset values: state = IDLE, o_PMWE = 0, o_PMADDR = BASE_ADDR, o_PMWDATA = 0, o_core_reset = 0, o_busy = 0, o_done = 0, o_error = 0. o_rx_ready = 1 once out of reset.
- i_reset mid-frame:
  - Abort immediately; no further writes.
  - Words already written stay in memory.
  - o_core_reset deasserts.
- Address wrap at 16'hFFFF → 16'h0000 is permitted; with the default MAX_WORDS it does not occur.

Test Plan:
- Normal load: bytes A5 00 02 34 12 EF BE F3 with valid held high.
  - Required: writes addr 0 = 16'h1234, then addr 1 = 16'hBEEF, each a single o_PMWE pulse.
  - o_rx_ready is low in each write cycle.
  - o_done pulses once, o_core_reset 1→0, o_error = 0.
- Bad checksum: same frame ending F4.
  - Required: both writes occur, o_error = 1, o_core_reset stays 1, no o_done.
  - Then A5 00 00 00: o_error clears, o_done pulses, o_core_reset = 0.
- Empty frame: A5 00 00 00.
  - Required: no o_PMWE, o_done pulses.
- Oversize length: A5 10 01 (N = 4097).
  - Required: ERROR right after LEN_L, no writes, o_error = 1.
- Garbage and gaps: 00 FF 5A before A5 00 01 CD AB 78, with i_rx_valid toggled randomly.
  - Required: garbage ignored, single write addr 0 = 16'hABCD, o_done pulses.
- Reset mid-load: i_reset asserted after A5 00 03 11 22.
  - Required: next cycle state IDLE, o_core_reset = 0, o_busy = 0.
  - The one write (16'h2211 at addr 0) remains; no further writes.
